x25519_request_sequencer: RTL
=============================

Name: x25519_request_sequencer

Overview:
- Front-end stage directly upstream of the curve25519 scalar-multiplication core.
- Accepts raw 256-bit scalar/u-coordinate requests over a valid/ready handshake and applies RFC 7748 clamping and masking.
- Issues the core's single-cycle start, tracks the core's done level through a full busy cycle, and returns the 255-bit result over a valid/ready handshake.
- Flags an all-zero result (low-order peer point) and watchdog timeouts.

Parameters:
- CLAMP, 1, 1 = apply RFC 7748 scalar clamping; 0 = pass scalar bits [254:0] unchanged.
- TIMEOUT, 1048576, max cycles allowed in ARM+BUSY before abort.
- CNT_W, 21, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_scalar  in  256  raw scalar, integer form
- in_point  in  256  raw peer u-coordinate, integer form
- core_start  out  1  single-cycle start pulse to core
- core_scalar  out  255  clamped scalar, held stable from start until done
- core_point  out  255  masked point, held stable from start until done
- core_done  in  1  core idle level: high = idle/result valid, low = busy
- core_out  in  255  core result, valid while core_done high after a run
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_result  out  255  registered result
- out_zero  out  1  out_result == 0
- out_timeout  out  1  run aborted by watchdog; out_result forced to 0

Behaviour:
- Reset values: in_ready=0, core_start=0, core_scalar=0, core_point=0, out_valid=0, out_result=0, out_zero=0, out_timeout=0, state=IDLE, watchdog=0.
- Clamp (CLAMP=1): core_scalar = {1'b1, in_scalar[253:3], 3'b000}. in_scalar[255] and [254] are discarded; bit 254 is forced to 1. CLAMP=0: core_scalar = in_scalar[254:0].
- Point: core_point = in_point[254:0] (bit 255 masked). Non-canonical values ≥ 2^255−19 pass through unchanged; reduction is the core's responsibility.
- FSM states: IDLE, START, ARM, BUSY, HOLD.
- IDLE:
  - in_ready = core_done && !out_valid (combinational).
  - On accept, register clamped scalar and masked point, then go to START.
- START: core_start=1 for exactly this cycle; watchdog cleared; go to ARM.
- ARM:
  - Wait for core_done=0 (core has taken the job); go to BUSY.
  - A core that completes without ever dropping done is a timeout.
- BUSY:
  - Wait for core_done=1.
  - Capture core_out into out_result, set out_zero = (core_out==0), out_timeout=0, out_valid=1; go to HOLD.
- ARM/BUSY watchdog:
  - Increments every cycle; at count == TIMEOUT−1, go to HOLD with out_valid=1, out_timeout=1, out_result=0, out_zero=0.
- HOLD:
  - out_valid stays high and out_result/out_zero/out_timeout stay stable until out_ready.
  - On the handshake, drop out_valid and go to IDLE.
  - A new request cannot be accepted in the same cycle as the out handshake.
- Latency: accept at cycle 0 → core_start at cycle 1 → out_valid in the cycle after core_done is first seen high in BUSY. Minimum accept-to-out_valid is 4 cycles with an instant core.
- core_scalar and core_point stay held after the run until the next accept.
- Reset mid-operation:
  - FSM returns to IDLE immediately; a pending output is discarded.
  - The core (no reset) may still be busy; in_ready stays 0 until core_done=1, so a stale run is never mistaken for a new result.
- in_valid while in_ready=0: ignored, no internal state change.

Decomposition:
- Shared package x25519_pkg:
  - constants P25519 = 2^255−19 and WORD_W = 255
  - function clamp_scalar(256-bit) → 255-bit
  - FSM state typedef
- No sub-module; clamping is a package function, watchdog is an inline counter.

Test Plan:
- Clamp: in_scalar=0xFFFF…FF (256 ones), CLAMP=1 → core_scalar = 0x7FFF…FFF8 (bit 254 set, low 3 bits 0); in_scalar=0 → core_scalar = 0x4000…0000.
- Point mask: in_point = 2^255 + 9 → core_point = 9; core_start high exactly one cycle, one cycle after accept.
- Mock core (done low 5 cycles after start, core_out=0x1234) → out_valid with out_result=0x1234, out_zero=0, out_timeout=0; out_ready held low 10 cycles → outputs stable, in_ready=0 throughout.
- Mock core returning 0 → out_zero=1. Real curve25519 core: private keys a, b with base 9 through two instances; a·(b·9) and b·(a·9) compared → results equal.
- Mock core never drops done; separately, never raises done, with TIMEOUT=16 → out_timeout=1, out_result=0 after 16 cycles in ARM/BUSY.
- Reset asserted in BUSY while the mock core keeps done low → in_ready=0 and out_valid=0 after reset until done rises. The next request then completes normally.

Source files
------------

// File: rtl/x25519_pkg.sv
// Shared definitions for the curve25519 request front-end.
// Contents: field widths, the field prime, the sequencer FSM state type and
// the RFC 7748 scalar clamp.
package x25519_pkg;

   localparam int unsigned WORD_W = 255;
   localparam int unsigned IN_W   = 256;

   // 2^255 - 19
   localparam logic [WORD_W-1:0] P25519 =
      255'h7fffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffffed;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ARM,
      ST_BUSY,
      ST_HOLD
   } state_e;

   // Drop bits 255/254, force bit 254 high, clear the cofactor bits [2:0].
   function automatic logic [WORD_W-1:0] clamp_scalar(input logic [IN_W-1:0] s);
      return {1'b1, s[253:3], 3'b000};
   endfunction

endpackage

// File: rtl/x25519_request_sequencer.sv
// Request sequencer in front of the curve25519 scalar-multiplication core.
// Accepts scalar/u-coordinate pairs, clamps/masks them, starts the core,
// follows its done level through a busy period and returns the result.
// Ports:
//   clock, reset              clock and async active-high reset
//   in_valid/in_ready         request handshake (in_ready is combinational)
//   in_scalar, in_point       raw 256-bit request operands
//   core_start                one-cycle start pulse to the core
//   core_scalar, core_point   operands held from start until next accept
//   core_done, core_out       core idle level and result
//   out_valid/out_ready       result handshake
//   out_result, out_zero      registered result and all-zero flag
//   out_timeout               run aborted by the watchdog (result forced 0)
module x25519_request_sequencer
   import x25519_pkg::*;
#(
   parameter bit          CLAMP   = 1'b1,
   parameter int unsigned TIMEOUT = 1048576,
   parameter int unsigned CNT_W   = 21
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_scalar,
   input  logic [IN_W-1:0]   in_point,
   output logic              core_start,
   output logic [WORD_W-1:0] core_scalar,
   output logic [WORD_W-1:0] core_point,
   input  logic              core_done,
   input  logic [WORD_W-1:0] core_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_timeout
);

   state_e              state_q, state_d;
   logic                start_q, start_d;
   logic [WORD_W-1:0]   scalar_q, scalar_d;
   logic [WORD_W-1:0]   point_q, point_d;
   logic [CNT_W-1:0]    wd_q, wd_d;
   logic                valid_q, valid_d;
   logic [WORD_W-1:0]   result_q, result_d;
   logic                zero_q, zero_d;
   logic                timeout_q, timeout_d;
   logic                wd_expired;
   logic                unused_msb;

   // Bit 255 of the point is always masked; bit 255 of the scalar is never used.
   assign unused_msb = ^{in_scalar[IN_W-1], in_point[IN_W-1]};

   // Gated by reset so nothing is offered while the block is held in reset.
   assign in_ready = !reset && (state_q == ST_IDLE) && core_done && !valid_q;

   assign wd_expired = (wd_q == CNT_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         scalar_q  <= '0;
         point_q   <= '0;
         wd_q      <= '0;
         valid_q   <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         scalar_q  <= scalar_d;
         point_q   <= point_d;
         wd_q      <= wd_d;
         valid_q   <= valid_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      scalar_d  = scalar_q;
      point_d   = point_q;
      wd_d      = wd_q;
      valid_d   = valid_q;
      result_d  = result_q;
      zero_d    = zero_q;
      timeout_d = timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               scalar_d = CLAMP ? clamp_scalar(in_scalar) : in_scalar[WORD_W-1:0];
               point_d  = in_point[WORD_W-1:0];
               start_d  = 1'b1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            wd_d    = '0;
            state_d = ST_ARM;
         end
         ST_ARM: begin
            wd_d = wd_q + CNT_W'(1);
            // Abort wins here: a core that never takes the job must not
            // be allowed past the watchdog by a late done drop.
            if (wd_expired) begin
               valid_d   = 1'b1;
               timeout_d = 1'b1;
               result_d  = '0;
               zero_d    = 1'b0;
               state_d   = ST_HOLD;
            end else if (!core_done) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            wd_d = wd_q + CNT_W'(1);
            // A result that is already present is kept rather than aborted.
            if (core_done) begin
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               result_d  = core_out;
               zero_d    = (core_out == '0);
               state_d   = ST_HOLD;
            end else if (wd_expired) begin
               valid_d   = 1'b1;
               timeout_d = 1'b1;
               result_d  = '0;
               zero_d    = 1'b0;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign core_start  = start_q;
   assign core_scalar = scalar_q;
   assign core_point  = point_q;
   assign out_valid   = valid_q;
   assign out_result  = result_q;
   assign out_zero    = zero_q;
   assign out_timeout = timeout_q;

endmodule
